// File: rtl/lcd_ctrl_param_if.sv
// Command, IROM-read and IRAM-write signal bundle for lcd_ctrl_param.
// Handshake: a command transfers on a rising edge with cmd_valid=1 and busy=0; cmd_valid while busy=1 is dropped, never queued.
interface lcd_ctrl_param_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          IRAM_valid;
  logic [AW-1:0] IRAM_A;
  logic [DW-1:0] IRAM_D;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image-window controller: loads an IMG_W x IMG_H image from IROM, applies 2x2 window
// commands around a movable point, and streams the buffer to IRAM on Write.
module lcd_ctrl_param #(
  parameter int  IMG_W = 8,
  parameter int  IMG_H = 8,
  parameter int  DW    = 8,
  parameter int  WRAP  = 0,
  localparam int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic            clk,
  input  logic            reset,
  lcd_ctrl_param_if.slave bus,
  output logic [2:0]      dbg_state
);
  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW:0]   N_CNT = (AW+1)'(N);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_CTR = XW'(IMG_W / 2);
  localparam logic [YW-1:0] Y_CTR = YW'(IMG_H / 2);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic [AW:0]   ld_cnt_q, ld_cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          rd_q, rd_d, ram_v_q, ram_v_d;
  logic [AW-1:0] rom_a_q, rom_a_d, ram_a_q, ram_a_d, ram_a_nxt;
  logic [DW-1:0] ram_d_q, ram_d_d;
  logic [DW-1:0] pix_q [N];
  logic [DW-1:0] pix_d [N];

  // Window around the operation point; x/y are the low/high address fields.
  logic [XW-1:0] xm1;
  logic [YW-1:0] ym1;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] v_tl, v_tr, v_bl, v_br;
  logic [DW-1:0] max_t, max_b, v_max, min_t, min_b, v_min, v_avg;
  logic [DW+1:0] sum;

  always_comb begin
    xm1   = px_q - X_ONE;
    ym1   = py_q - Y_ONE;
    a_tl  = {ym1, xm1};
    a_tr  = {ym1, px_q};
    a_bl  = {py_q, xm1};
    a_br  = {py_q, px_q};
    v_tl  = pix_q[a_tl];
    v_tr  = pix_q[a_tr];
    v_bl  = pix_q[a_bl];
    v_br  = pix_q[a_br];
    max_t = (v_tl > v_tr) ? v_tl : v_tr;
    max_b = (v_bl > v_br) ? v_bl : v_br;
    v_max = (max_t > max_b) ? max_t : max_b;
    min_t = (v_tl < v_tr) ? v_tl : v_tr;
    min_b = (v_bl < v_br) ? v_bl : v_br;
    v_min = (min_t < min_b) ? min_t : min_b;
    sum   = {2'b00, v_tl} + {2'b00, v_tr} + {2'b00, v_bl} + {2'b00, v_br};
    v_avg = sum[DW+1:2];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (rd_q && rom_a_q == LAST) state_d = S_IDLE;
      S_IDLE:  if (bus.cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = (cmd_q == 4'h0) ? S_WRITE : S_IDLE;
      S_WRITE: if (ram_a_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    cmd_d     = cmd_q;
    px_d      = px_q;
    py_d      = py_q;
    pix_d     = pix_q;
    ld_cnt_d  = ld_cnt_q;
    rd_d      = 1'b0;
    rom_a_d   = rom_a_q;
    ram_v_d   = 1'b0;
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    ram_a_nxt = ram_a_q + 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    // IROM data arrives one cycle after its request, so capture under last cycle's address.
    if (rd_q) pix_d[rom_a_q] = bus.IROM_Q;
    unique case (state_q)
      S_LOAD: if (ld_cnt_q != N_CNT) begin
        rd_d     = 1'b1;
        rom_a_d  = ld_cnt_q[AW-1:0];
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
      S_IDLE: if (bus.cmd_valid) cmd_d = bus.cmd;
      S_EXEC: begin
        unique case (cmd_q)
          4'h0: begin ram_v_d = 1'b1; ram_a_d = '0; ram_d_d = pix_q[0]; end
          4'h1: if (py_q != Y_ONE) py_d = py_q - Y_ONE; else if (WRAP != 0) py_d = Y_MAX;
          4'h2: if (py_q != Y_MAX) py_d = py_q + Y_ONE; else if (WRAP != 0) py_d = Y_ONE;
          4'h3: if (px_q != X_ONE) px_d = px_q - X_ONE; else if (WRAP != 0) px_d = X_MAX;
          4'h4: if (px_q != X_MAX) px_d = px_q + X_ONE; else if (WRAP != 0) px_d = X_ONE;
          4'h5: begin pix_d[a_tl] = v_max; pix_d[a_tr] = v_max; pix_d[a_bl] = v_max; pix_d[a_br] = v_max; end
          4'h6: begin pix_d[a_tl] = v_min; pix_d[a_tr] = v_min; pix_d[a_bl] = v_min; pix_d[a_br] = v_min; end
          4'h7: begin pix_d[a_tl] = v_avg; pix_d[a_tr] = v_avg; pix_d[a_bl] = v_avg; pix_d[a_br] = v_avg; end
          4'h8: begin pix_d[a_tl] = v_tr; pix_d[a_tr] = v_br; pix_d[a_br] = v_bl; pix_d[a_bl] = v_tl; end
          4'h9: begin pix_d[a_tl] = v_bl; pix_d[a_bl] = v_br; pix_d[a_br] = v_tr; pix_d[a_tr] = v_tl; end
          4'hA: begin pix_d[a_tl] = v_bl; pix_d[a_bl] = v_tl; pix_d[a_tr] = v_br; pix_d[a_br] = v_tr; end
          4'hB: begin pix_d[a_tl] = v_tr; pix_d[a_tr] = v_tl; pix_d[a_bl] = v_br; pix_d[a_br] = v_bl; end
          4'hC: begin px_d = X_CTR; py_d = Y_CTR; end
          4'hD: begin pix_d[a_tl] = v_br; pix_d[a_br] = v_tl; end
          default: ;
        endcase
      end
      S_WRITE: if (ram_a_q != LAST) begin
        ram_v_d = 1'b1;
        ram_a_d = ram_a_nxt;
        ram_d_d = pix_q[ram_a_nxt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      cmd_q    <= '0;
      px_q     <= X_CTR;
      py_q     <= Y_CTR;
      ld_cnt_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      rom_a_q  <= '0;
      ram_v_q  <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      px_q     <= px_d;
      py_q     <= py_d;
      ld_cnt_q <= ld_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      rom_a_q  <= rom_a_d;
      ram_v_q  <= ram_v_d;
      ram_a_q  <= ram_a_d;
      ram_d_q  <= ram_d_d;
    end
  end

  // The buffer is not reset: every reset is followed by a full reload.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) pix_q[i] <= pix_d[i];
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.IROM_rd    = rd_q;
  assign bus.IROM_A     = rom_a_q;
  assign bus.IRAM_valid = ram_v_q;
  assign bus.IRAM_A     = ram_a_q;
  assign bus.IRAM_D     = ram_d_q;
  assign dbg_state      = state_q;
endmodule
